func_sched: RTL

Upstream issue stage for the cube-plus-isqrt unit `func`, which computes y = a^3 + floor(sqrt(b)).
- Buffers operand pairs from a valid/ready source in a small FIFO.
- Sequences each pair through `func`: clear pulse, then start pulse, then waits for busy to rise and fall.
- Captures the 24-bit result and presents it on a valid/ready result port.
- Flags an error when the unit never acknowledges a start.

---
 rtl/func_pkg.sv | 23 ++
 rtl/func_sched_if.sv | 43 ++++
 rtl/func_sched_fifo.sv | 49 ++++
 rtl/func_sched.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/func_pkg.sv
// func_pkg: shared types and constants for the func issue stage.
package func_pkg;

    localparam int OP_W = 8;
    localparam int Y_W  = 24;

    localparam logic [Y_W-1:0] Y_TIMEOUT = 24'hFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_t;

endpackage

// File: rtl/func_sched_if.sv
// func_sched_if: operand, result and func-side signals of the issue stage.
interface func_sched_if #(
    parameter int DEPTH = 4
);
    import func_pkg::*;

    logic                  op_valid_i;
    logic                  op_ready_o;
    logic [OP_W-1:0]       op_a_i;
    logic [OP_W-1:0]       op_b_i;
    logic                  func_rst_o;
    logic                  func_start_o;
    logic [OP_W-1:0]       func_a_o;
    logic [OP_W-1:0]       func_b_o;
    logic                  func_busy_i;
    logic [Y_W-1:0]        func_y_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [Y_W-1:0]        res_y_o;
    logic [OP_W-1:0]       res_a_o;
    logic [OP_W-1:0]       res_b_o;
    logic                  err_o;
    logic [$clog2(DEPTH):0] level_o;

    modport master (
        input  op_valid_i, op_a_i, op_b_i,
        input  func_busy_i, func_y_i, res_ready_i,
        output op_ready_o, func_rst_o, func_start_o,
        output func_a_o, func_b_o,
        output res_valid_o, res_y_o, res_a_o, res_b_o,
        output err_o, level_o
    );

    modport slave (
        output op_valid_i, op_a_i, op_b_i,
        output func_busy_i, func_y_i, res_ready_i,
        input  op_ready_o, func_rst_o, func_start_o,
        input  func_a_o, func_b_o,
        input  res_valid_o, res_y_o, res_a_o, res_b_o,
        input  err_o, level_o
    );

endinterface

// File: rtl/func_sched_fifo.sv
// func_sched_fifo: DEPTH-entry synchronous FIFO with occupancy output.
module func_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_din,
    output logic [W-1:0]           o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_lvl;

    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wr] <= i_din;
    end

    // Power-of-two depth lets the pointers wrap on overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_lvl <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            unique case ({i_push, i_pop})
                2'b10:   r_lvl <= r_lvl + 1'b1;
                2'b01:   r_lvl <= r_lvl - 1'b1;
                default: r_lvl <= r_lvl;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_full  = (r_lvl == (AW+1)'(DEPTH));
    assign o_empty = (r_lvl == '0);
    assign o_level = r_lvl;

endmodule

// File: rtl/func_sched.sv
// func_sched: issue stage for the cube-plus-isqrt unit func.
// Buffers operand pairs, runs one at a time through func, holds the result.
module func_sched
    import func_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    func_sched_if.master bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          r_state, w_nxt;
    logic            r_frst, w_frst;
    logic            r_fstart, w_fstart;
    logic [OP_W-1:0] r_fa, w_fa;
    logic [OP_W-1:0] r_fb, w_fb;
    logic [OP_W-1:0] r_ra, w_ra;
    logic [OP_W-1:0] r_rb, w_rb;
    logic [Y_W-1:0]  r_y, w_y;
    logic            r_valid, w_valid;
    logic            r_err, w_err;
    logic [CW-1:0]   r_cnt, w_cnt;

    logic            w_push;
    logic            w_pop;
    logic            w_ready;
    logic            w_full;
    logic            w_empty;
    op_t             w_din;
    op_t             w_head;
    logic [LW-1:0]   w_level;

    assign w_din.a = bus.op_a_i;
    assign w_din.b = bus.op_b_i;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_ready = rst_i & (~w_full | w_pop);
    assign w_push  = bus.op_valid_i & w_ready;

    func_sched_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(op_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_nxt    = r_state;
        w_pop    = 1'b0;
        w_frst   = 1'b0;
        w_fstart = 1'b0;
        w_fa     = r_fa;
        w_fb     = r_fb;
        w_ra     = r_ra;
        w_rb     = r_rb;
        w_y      = r_y;
        w_valid  = r_valid;
        w_err    = r_err;
        w_cnt    = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_frst = 1'b1;
                    w_fa   = w_head.a;
                    w_fb   = w_head.b;
                    w_nxt  = CLR;
                end
            end
            CLR: begin
                w_fstart = 1'b1;
                w_nxt    = START;
            end
            START: begin
                w_cnt = '0;
                w_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.func_busy_i) begin
                    w_nxt = WAIT_DONE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_err   = 1'b1;
                    w_y     = Y_TIMEOUT;
                    w_ra    = r_fa;
                    w_rb    = r_fb;
                    w_valid = 1'b1;
                    w_nxt   = HOLD;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.func_busy_i) begin
                    w_y     = bus.func_y_i;
                    w_ra    = r_fa;
                    w_rb    = r_fb;
                    w_valid = 1'b1;
                    w_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready_i) begin
                    w_valid = 1'b0;
                    w_nxt   = IDLE;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= IDLE;
            r_frst   <= 1'b0;
            r_fstart <= 1'b0;
            r_fa     <= '0;
            r_fb     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_y      <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_nxt;
            r_frst   <= w_frst;
            r_fstart <= w_fstart;
            r_fa     <= w_fa;
            r_fb     <= w_fb;
            r_ra     <= w_ra;
            r_rb     <= w_rb;
            r_y      <= w_y;
            r_valid  <= w_valid;
            r_err    <= w_err;
            r_cnt    <= w_cnt;
        end
    end

    assign bus.op_ready_o   = w_ready;
    assign bus.func_rst_o   = r_frst;
    assign bus.func_start_o = r_fstart;
    assign bus.func_a_o     = r_fa;
    assign bus.func_b_o     = r_fb;
    assign bus.res_valid_o  = r_valid;
    assign bus.res_y_o      = r_y;
    assign bus.res_a_o      = r_ra;
    assign bus.res_b_o      = r_rb;
    assign bus.err_o        = r_err;
    assign bus.level_o      = w_level;

endmodule
